// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: default widths, channel roles and
// the 100 MHz reset divisors.
package tick_gen_pkg;

  localparam int CNT_W_DEFAULT  = 27;
  localparam int NUM_CH_DEFAULT = 4;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  localparam int CH_DISP_MUX = 0;
  localparam int CH_ONE_HZ   = 1;
  localparam int CH_TWO_HZ   = 2;
  localparam int CH_BLINK    = 3;

  // Channel 0 sits in the LSBs.
  localparam logic [NUM_CH_DEFAULT*CNT_W_DEFAULT-1:0] DIV_INIT_DEFAULT = {
    27'd250_000, 27'd25_000_000, 27'd50_000_000, 27'd100_000
  };

endpackage

// File: rtl/tick_gen_channel.sv
// One tick channel: shadow/active divisor pair, phase counter, tick and
// optional level output (built only with TICK_GEN_LEVEL_OUT_EN).
module tick_gen_channel #(
  parameter int               CNT_W   = 27,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_val_i,
  output logic             tick_o,
  output logic             level_o
);

  logic [CNT_W-1:0] shd_q, shd_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] last_cnt;
  logic             wrap;

  // Divisors 0 and 1 both collapse to a terminal count of 0.
  always_comb begin
    last_cnt = (act_q > CNT_W'(1)) ? act_q - CNT_W'(1) : '0;
    wrap     = en_i && (cnt_q == last_cnt);
  end

  always_comb begin
    shd_d  = we_i ? div_val_i : shd_q;
    act_d  = act_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
      act_d = shd_d;
    end else if (wrap) begin
      cnt_d  = '0;
      act_d  = shd_d;
      tick_d = 1'b1;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shd_q  <= DIV_RST;
      act_q  <= DIV_RST;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

`ifdef TICK_GEN_LEVEL_OUT_EN
  logic level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (clr_i) begin
      level_d = 1'b0;
    end else if (wrap) begin
      level_d = ~level_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
`else
  assign level_o = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator; level outputs exist only when
// TICK_GEN_LEVEL_OUT_EN is defined, otherwise level is tied low.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int                        NUM_CH   = NUM_CH_DEFAULT,
  parameter int                        CNT_W    = CNT_W_DEFAULT,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = DIV_INIT_DEFAULT,
  localparam int                       SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level
);

  // Selects that match no channel simply enable no write.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_ch;
    assign we_ch = div_we && (div_sel == SEL_W'(i));

    tick_gen_channel #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (rst),
      .en_i      (en),
      .clr_i     (clr),
      .we_i      (we_ch),
      .div_val_i (div_val),
      .tick_o    (tick[i]),
      .level_o   (level[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: periods, pause, divisor writes, clear and reset.
module tb_tick_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 27;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd6, 27'd4, 27'd3, 27'd2};
`ifdef TICK_GEN_LEVEL_OUT_EN
  localparam logic LVL_ON = 1'b1;
`else
  localparam logic LVL_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clr;
  logic              div_we;
  logic [1:0]        div_sel;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] level;

  int vectors    = 0;
  int miscompares = 0;

  tick_gen #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .div_we  (div_we),
    .div_sel (div_sel),
    .div_val (div_val),
    .tick    (tick),
    .level   (level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; clr = 1'b0; div_we = 1'b0; div_sel = '0; div_val = '0;
    repeat (3) step();
    vectors++;
    if (tick !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_tick: got %b expected 0000", tick);
    end
    vectors++;
    if (level !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_level: got %b expected 0000", level);
    end
    rst = 1'b1;
  endtask

  // Divisors {6,4,3,2}: tick after edge k iff D divides k; level = floor(k/D) odd.
  task automatic test_periods();
    int d[4] = '{2, 3, 4, 6};
    logic [3:0] te, le;
    for (int k = 1; k <= 24; k++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        te[c] = (k % d[c]) == 0;
        le[c] = LVL_ON & (((k / d[c]) % 2) == 1);
      end
      vectors++;
      if (tick !== te) begin
        miscompares++;
        $display("[TB] FAIL periods_tick k=%0d: got %b expected %b", k, tick, te);
      end
      vectors++;
      if (level !== le) begin
        miscompares++;
        $display("[TB] FAIL periods_level k=%0d: got %b expected %b", k, level, le);
      end
    end
  endtask

  task automatic test_pause();
    div_we = 1'b1; div_sel = 2'd0; div_val = 27'd5; clr = 1'b1; en = 1'b1;
    step();
    div_we = 1'b0; clr = 1'b0;
    vectors++;
    if (tick !== 4'b0000 || level !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL pause_clr: got tick %b level %b expected 0000/0000", tick, level);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      vectors++;
      if (tick[0] !== (k == 5)) begin
        miscompares++;
        $display("[TB] FAIL pause_pre k=%0d: got %b expected %b", k, tick[0], (k == 5));
      end
    end
    for (int k = 1; k <= 12; k++) begin
      en = (k >= 3 && k <= 9) ? 1'b0 : 1'b1;
      step();
      if (!en) begin
        vectors++;
        if (tick !== 4'b0000) begin
          miscompares++;
          $display("[TB] FAIL pause_hold k=%0d: got %b expected 0000", k, tick);
        end
      end
      vectors++;
      if (tick[0] !== (k == 12)) begin
        miscompares++;
        $display("[TB] FAIL pause_resume k=%0d: got %b expected %b", k, tick[0], (k == 12));
      end
    end
    en = 1'b1;
  endtask

  // Channel 1: D=8, write 3 mid-count, then 8 mid-count, then 3 on the wrap edge.
  task automatic test_div_write();
    logic te;
    div_we = 1'b1; div_sel = 2'd1; div_val = 27'd8; clr = 1'b1; en = 1'b1;
    step();
    div_we = 1'b0; clr = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      div_we = (k == 3 || k == 15 || k == 25);
      div_sel = 2'd1;
      div_val = (k == 15) ? 27'd8 : 27'd3;
      step();
      div_we = 1'b0;
      te = (k == 8 || k == 11 || k == 14 || k == 17 || k == 25 || k == 28 || k == 31);
      vectors++;
      if (tick[1] !== te) begin
        miscompares++;
        $display("[TB] FAIL div_write k=%0d: got %b expected %b", k, tick[1], te);
      end
    end
  endtask

  task automatic test_div_zero_one();
    div_we = 1'b1; div_sel = 2'd2; div_val = 27'd0; clr = 1'b1; en = 1'b1;
    step();
    div_we = 1'b0; clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      div_we = (k == 4); div_sel = 2'd2; div_val = 27'd1;
      step();
      div_we = 1'b0;
      vectors++;
      if (tick[2] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL div01_tick k=%0d: got %b expected 1", k, tick[2]);
      end
      vectors++;
      if (level[2] !== (LVL_ON & ((k % 2) == 1))) begin
        miscompares++;
        $display("[TB] FAIL div01_level k=%0d: got %b expected %b", k, level[2],
                 LVL_ON & ((k % 2) == 1));
      end
    end
  endtask

  // Divisors now {5,3,1,6}; the second clear lands on a wrap of channels 0 and 2.
  task automatic test_clr();
    int d[4] = '{5, 3, 1, 6};
    logic [3:0] te, le;
    clr = 1'b1; en = 1'b1;
    step();
    clr = 1'b0;
    repeat (4) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    vectors++;
    if (tick !== 4'b0000 || level !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL clr_wrap: got tick %b level %b expected 0000/0000", tick, level);
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        te[c] = (k % d[c]) == 0;
        le[c] = LVL_ON & (((k / d[c]) % 2) == 1);
      end
      vectors++;
      if (tick !== te || level !== le) begin
        miscompares++;
        $display("[TB] FAIL clr_align k=%0d: got tick %b level %b expected %b/%b",
                 k, tick, level, te, le);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d[4] = '{2, 3, 4, 6};
    logic [3:0] te;
    step();
    vectors++;
    if (tick[2] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pre: got %b expected 1", tick[2]);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (tick !== 4'b0000 || level !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async: got tick %b level %b expected 0000/0000", tick, level);
    end
    step();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      for (int c = 0; c < 4; c++) te[c] = (k % d[c]) == 0;
      vectors++;
      if (tick !== te) begin
        miscompares++;
        $display("[TB] FAIL rstmid_div k=%0d: got %b expected %b", k, tick, te);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periods();
    test_pause();
    test_div_write();
    test_div_zero_one();
    test_clr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised multi-channel clock-enable generator for the stopwatch and its successors. It produces NUM_CH independent single-cycle tick pulses from the one system clock, each at a runtime-programmable divide ratio. It also produces optional 50 %-duty level outputs. Downstream counters, the display multiplexer and the blink logic run on `clk` and qualify updates with these ticks; no derived clocks are generated.

## Interface
- `NUM_CH`, default 4: number of independent channels.
- `CNT_W`, default 27: divisor and counter width in bits.
- `DIV_INIT`, default {27'd250_000, 27'd25_000_000, 27'd50_000_000, 27'd100_000}: packed NUM_CH×CNT_W reset divisors, channel 0 in the LSBs.
- `clk  in  1`: system clock, 100 MHz nominal.
- `rst  in  1`: reset, asynchronous and active-low.
- `en  in  1`: run enable, shared by all channels.
- `clr  in  1`: synchronous clear of all channel phases.
- `div_we  in  1`: divisor write strobe.
- `div_sel  in  $clog2(NUM_CH)`: channel addressed by the write.
- `div_val  in  CNT_W`: divisor value to write.
- `tick  out  NUM_CH`: one-cycle pulse per channel, registered.
- `level  out  NUM_CH`: per-channel square wave that toggles on each tick, registered.

## Operation
- Each channel holds three registers:
  - shadow divisor `shd`
  - active divisor `act`
  - counter `cnt` (0..act-1)
- Effective divisor D = max(act, 1). Values 0 and 1 both give a tick every enabled cycle.
- Enabled cycle with `cnt == D-1`: this is a wrap.
  - `cnt` goes to 0.
  - `tick` is 1 in the next cycle.
  - `level` toggles.
  - `act` loads `shd`.
- Enabled cycle with no wrap: `cnt` increments and `tick` is 0.
- `en=0`: `cnt`, `act` and `level` hold; `tick` is 0.
- Divisor write: `div_we=1` writes `div_val` into `shd[div_sel]`.
  - An out-of-range `div_sel` is ignored.
  - `act` changes only at a wrap or a `clr`, so a period is never cut short or stretched mid-count.
- Write on the same edge as a wrap of that channel: the written value passes straight through into `act`, and the next period uses the new value.
- `clr=1`: every channel behaves as follows, regardless of `en`.
  - `cnt` goes to 0.
  - `tick` is 0.
  - `level` is 0.
  - `act` loads `shd`, including a `div_we` write on the same edge.
  - `clr` has priority over a wrap.
- Channels are fully independent apart from the shared `en` and `clr`.

## Timing
- Reset (`rst=0`, asynchronous):
  - `cnt` = 0.
  - `shd` = `act` = DIV_INIT slice.
  - `tick` = 0.
  - `level` = 0.
- Reset released with `en` held at 1: the first `tick` of a channel is high during the cycle after the D-th rising edge. Later ticks are exactly D cycles apart.
- `tick` is always exactly one cycle wide. D=1 is the exception: `tick` stays high continuously while `en=1`.
- `level` period is 2D cycles at 50 % duty; it changes in the same cycle `tick` rises.
- Pause: with `en` low for k cycles, the next tick moves out by exactly k cycles.
- `clr` deasserted at edge E with `en=1`: the first tick follows D edges later, so all channels are phase-aligned.
- `rst` asserted mid-count: outputs drop at once, with no partial tick.

## Configuration
- `TICK_GEN_LEVEL_OUT_EN` defined: the `level` registers and toggle logic are built as described.
- Macro not defined: no `level` registers are built, and `level` is tied to 0. All tick behaviour is identical in both builds.

## Structure
- Package `tick_gen_pkg` holds:
  - `CNT_W` default
  - typedef `div_t` (logic [CNT_W-1:0])
  - channel index constants `CH_DISP_MUX=0`, `CH_ONE_HZ=1`, `CH_TWO_HZ=2`, `CH_BLINK=3`
  - the 100 MHz `DIV_INIT` defaults
- Sub-module `tick_gen_channel` is one channel: `shd`, `act`, `cnt`, `tick`, `level`, with a local write enable (`div_we && div_sel==i`). The top decodes `div_sel` and instantiates NUM_CH copies with a generate loop.

## Test plan
- Reset, then `en=1`, NUM_CH=4, DIV_INIT={6,4,3,2}:
  - ticks appear every 2/3/4/6 cycles respectively.
  - first ticks fall after edges 2/3/4/6.
  - `level` periods are 4/6/8/12.
- Channel 0 with D=5, `en` dropped for 7 cycles mid-count:
  - no tick while paused.
  - the next tick is 12 cycles after the previous one.
- Write `div_val=3` to channel 1 (D=8) at `cnt=2`:
  - the current period still completes at 8 cycles.
  - all later periods are 3 cycles.
  - repeat with the write on the wrap edge: the next period is 3.
- Write `div_val` 0 and then 1:
  - `tick` stays high every cycle.
  - `level` toggles every cycle.
- Pulse `clr` while channels are out of phase:
  - `tick` and `level` are all 0 the next cycle.
  - the channels then restart aligned.
  - `clr` coinciding with a wrap suppresses that tick.
- Assert `rst` low mid-period: outputs go to 0 asynchronously and divisors return to DIV_INIT. Build without `TICK_GEN_LEVEL_OUT_EN`: `level` is constantly 0.
